// File: rtl/apb_nslave_master_if.sv
// Command-port and APB bus signals for the N-slave APB master bridge.
// The master modport is the bridge view; the slave modport is the environment view.
interface apb_nslave_master_if #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int NUM_SLAVES = 4
);
    logic                     transfer;
    logic                     read_write;
    logic [AW-1:0]            cmd_addr;
    logic [DW-1:0]            cmd_wdata;
    logic                     cmd_ready;
    logic                     rsp_valid;
    logic [DW-1:0]            rsp_rdata;
    logic                     rsp_err;
    logic [AW-1:0]            paddr;
    logic [NUM_SLAVES-1:0]    psel;
    logic                     penable;
    logic                     pwrite;
    logic [DW-1:0]            pwdata;
    logic [NUM_SLAVES*DW-1:0] prdata;
    logic [NUM_SLAVES-1:0]    pready;
    logic [NUM_SLAVES-1:0]    pslverr;

    modport master (
        input  transfer, read_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output transfer, read_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/apb_nslave_master.sv
// APB master bridge: one command at a time, routed to one of NUM_SLAVES slaves by the
// top address bits, with wait-state, slave-error, decode-error and timeout handling.
module apb_nslave_master #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_BITS   = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                 pclk,
    input  logic                 presetn,
    apb_nslave_master_if.master  bus
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : {TW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic [AW-1:0]         r_paddr;
    logic [NUM_SLAVES-1:0] r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [DW-1:0]         r_pwdata;
    logic                  r_rsp_valid;
    logic [DW-1:0]         r_rsp_rdata;
    logic                  r_rsp_err;
    logic [TW-1:0]         r_wait_cnt;

    logic [SEL_BITS-1:0]   w_idx;
    logic [NUM_SLAVES-1:0] w_psel_dec;
    logic                  w_dec_ok;
    logic                  w_ready;
    logic                  w_slverr;
    logic [DW-1:0]         w_prdata;

    assign w_idx = bus.cmd_addr[AW-1 -: SEL_BITS];

    // Slave-index decode; an index with no matching slave leaves the one-hot empty.
    always_comb begin
        w_psel_dec = {NUM_SLAVES{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_psel_dec[i] = (w_idx == SEL_BITS'(i));
        end
        w_dec_ok = |w_psel_dec;
    end

    // Response mux: only the currently selected slave contributes, others are masked off.
    always_comb begin
        w_ready  = 1'b0;
        w_slverr = 1'b0;
        w_prdata = {DW{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_ready  = w_ready  | (bus.pready[i]  & r_psel[i]);
            w_slverr = w_slverr | (bus.pslverr[i] & r_psel[i]);
            w_prdata = w_prdata | (bus.prdata[i*DW +: DW] & {DW{r_psel[i]}});
        end
    end

    // Transfer FSM with all bus and response outputs registered.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_paddr     <= {AW{1'b0}};
            r_psel      <= {NUM_SLAVES{1'b0}};
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= {DW{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DW{1'b0}};
            r_rsp_err   <= 1'b0;
            r_wait_cnt  <= {TW{1'b0}};
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.transfer) begin
                        r_paddr  <= bus.cmd_addr;
                        r_pwrite <= bus.read_write;
                        r_pwdata <= bus.cmd_wdata;
                        if (w_dec_ok) begin
                            r_psel      <= w_psel_dec;
                            r_penable   <= 1'b0;
                            r_cmd_ready <= 1'b0;
                            r_state     <= ST_SETUP;
                        end else begin
                            // Decode error: answer straight from IDLE, no bus cycle.
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= {DW{1'b0}};
                            r_state     <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= {TW{1'b0}};
                    r_state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_ready) begin
                        r_psel      <= {NUM_SLAVES{1'b0}};
                        r_penable   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_slverr;
                        r_rsp_rdata <= (!r_pwrite && !w_slverr) ? w_prdata : {DW{1'b0}};
                        r_state     <= ST_IDLE;
                    end else if ((TIMEOUT != 0) && (r_wait_cnt == TO_LAST)) begin
                        r_psel      <= {NUM_SLAVES{1'b0}};
                        r_penable   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= {DW{1'b0}};
                        r_wait_cnt  <= {TW{1'b0}};
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                        r_state    <= ST_ACCESS;
                    end
                end
                default: begin
                    r_psel      <= {NUM_SLAVES{1'b0}};
                    r_penable   <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_wait_cnt  <= {TW{1'b0}};
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.paddr     = r_paddr;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule
